fc_param_loader: RTL

FC_PARAM_LOADER -- requirements
Module: fc_param_loader

---
 rtl/fc_nn_pkg.sv | 23 ++
 rtl/fc_param_loader_if.sv | 13 +
 rtl/fc_param_bank.sv | 62 ++++++
 rtl/fc_param_loader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fc_nn_pkg.sv
// Shared definitions for the fully-connected layer parameter loader:
// layer geometry, byte width, loader state encoding and counter sizing.
package fc_nn_pkg;

    localparam int DATA_W = 8;
    localparam int N_IN   = 10;
    localparam int N_OUT  = 10;
    localparam int N_W    = N_IN * N_OUT;
    localparam int N_P    = N_W + N_OUT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_DRAIN  = 2'd3
    } fc_state_e;

    // Byte counter width: enough to index every parameter byte, never under 7 bits.
    function automatic int cnt_width(input int n_bytes);
        return ($clog2(n_bytes) > 7) ? $clog2(n_bytes) : 7;
    endfunction

endpackage

// File: rtl/fc_param_loader_if.sv
// Byte stream carrying weights followed by biases into the parameter loader.
interface fc_param_loader_if;
    import fc_nn_pkg::*;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/fc_param_bank.sv
// Parameter byte storage. With FC_PARAM_SHADOW_EN defined, bytes land in a
// shadow bank and the whole image is copied to the live bank on commit;
// otherwise bytes are written straight into the live bank.
module fc_param_bank
    import fc_nn_pkg::*;
#(
    parameter int N_BYTES = fc_nn_pkg::N_P,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
`ifdef FC_PARAM_SHADOW_EN
    input  logic              commit,
`endif
    output logic [DATA_W-1:0] params [N_BYTES]
);

    logic [DATA_W-1:0] live_r [N_BYTES];

`ifdef FC_PARAM_SHADOW_EN
    logic [DATA_W-1:0] shadow_r [N_BYTES];

    // Stage incoming bytes in the shadow bank while a load is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BYTES; i++) shadow_r[i] <= {DATA_W{1'b0}};
        end else if (we) begin
            for (int i = 0; i < N_BYTES; i++) begin
                if (waddr == ADDR_W'(i)) shadow_r[i] <= wdata;
            end
        end
    end

    // Copy the full image on commit; the final byte arrives on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BYTES; i++) live_r[i] <= {DATA_W{1'b0}};
        end else if (commit) begin
            for (int i = 0; i < N_BYTES; i++) begin
                live_r[i] <= (we && (waddr == ADDR_W'(i))) ? wdata : shadow_r[i];
            end
        end
    end
`else
    // Write each accepted byte directly into the live bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BYTES; i++) live_r[i] <= {DATA_W{1'b0}};
        end else if (we) begin
            for (int i = 0; i < N_BYTES; i++) begin
                if (waddr == ADDR_W'(i)) live_r[i] <= wdata;
            end
        end
    end
`endif

    assign params = live_r;

endmodule

// File: rtl/fc_param_loader.sv
// Fully-connected layer parameter loader: accepts a framed byte stream of
// N_IN*N_OUT weights followed by N_OUT biases and presents them as arrays.
// Optional feature macro: FC_PARAM_SHADOW_EN (atomic shadow-bank commit).
module fc_param_loader
    import fc_nn_pkg::*;
#(
    parameter int N_IN  = fc_nn_pkg::N_IN,
    parameter int N_OUT = fc_nn_pkg::N_OUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    fc_param_loader_if.slave  s,
    output logic [DATA_W-1:0] weights [N_IN*N_OUT],
    output logic [DATA_W-1:0] biases  [N_OUT],
    output logic              params_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int N_W   = N_IN * N_OUT;
    localparam int N_P   = N_W + N_OUT;
    localparam int CNT_W = cnt_width(N_P);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] LOAD_W = ST_LOAD_W;
    localparam logic [1:0] LOAD_B = ST_LOAD_B;
    localparam logic [1:0] DRAIN  = ST_DRAIN;

    localparam logic [CNT_W-1:0] CNT_LAST_W = CNT_W'(N_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_P = CNT_W'(N_P - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]        state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              active_r, done_r, err_r, pv_r;
    logic              done_nxt_s, err_nxt_s, pv_nxt_s, we_s, xfer_s;
`ifdef FC_PARAM_SHADOW_EN
    logic              commit_s;
`endif
    logic [DATA_W-1:0] params_s [N_P];

    assign xfer_s = s.s_valid && active_r;

    // Next-state, counter and flag decode for one byte transfer per edge.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = err_r;
        pv_nxt_s    = pv_r;
        we_s        = 1'b0;
`ifdef FC_PARAM_SHADOW_EN
        commit_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD_W;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    err_nxt_s   = 1'b0;
`ifndef FC_PARAM_SHADOW_EN
                    pv_nxt_s    = 1'b0;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_W, LOAD_B: begin
                if (xfer_s) begin
                    we_s = 1'b1;
                    if (s.s_last) begin
                        state_nxt_s = IDLE;
                        if (cnt_r == CNT_LAST_P) begin
                            done_nxt_s = 1'b1;
                            pv_nxt_s   = 1'b1;
`ifdef FC_PARAM_SHADOW_EN
                            commit_s   = 1'b1;
`endif
                        end else begin
                            err_nxt_s = 1'b1;
                        end
                    end else if (cnt_r == CNT_LAST_P) begin
                        // Frame overran: swallow bytes until the sender ends it.
                        state_nxt_s = DRAIN;
                        err_nxt_s   = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST_W) begin
                            state_nxt_s = LOAD_B;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DRAIN: begin
                if (xfer_s && s.s_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            pv_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            active_r <= (state_nxt_s != IDLE);
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            pv_r     <= pv_nxt_s;
        end
    end

    fc_param_bank #(
        .N_BYTES (N_P),
        .ADDR_W  (CNT_W)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .we     (we_s),
        .waddr  (cnt_r),
        .wdata  (s.s_data),
`ifdef FC_PARAM_SHADOW_EN
        .commit (commit_s),
`endif
        .params (params_s)
    );

    // Split the flat byte image into weight and bias views.
    always_comb begin
        for (int i = 0; i < N_W; i++) weights[i] = params_s[i];
        for (int m = 0; m < N_OUT; m++) biases[m] = params_s[N_W + m];
    end

    assign s.s_ready    = active_r;
    assign busy         = active_r;
    assign done         = done_r;
    assign err          = err_r;
    assign params_valid = pv_r;

endmodule
